// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg: shared register-file constants and flattened-bus helpers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic int dest_lo(input int idx);
        return idx * REG_ADDR_W;
    endfunction

    function automatic int data_lo(input int idx, input int xlen);
        return idx * xlen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: round-robin one-hot grant with registered priority ptr   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Search starts at the pointer and wraps upward; first valid requester wins.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr_q) + k) % N);
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                ptr_d          = (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
            end
        end
        if (!reset) begin
            grant_o = '0;
            ptr_d   = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_arbiter: shared RF write port arbiter + pending scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*NREQ-1:0] req_dest,
    input  logic [XLEN*NREQ-1:0]       req_data,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_dest,
    output logic                       issue_ready,
    input  logic [REG_ADDR_W-1:0]      src_one,
    input  logic [REG_ADDR_W-1:0]      src_two,
    output logic                       hazard_one,
    output logic                       hazard_two,
    output logic [REG_ADDR_W-1:0]      rf_dest,
    output logic                       rf_write_enable,
    output logic [XLEN-1:0]            rf_data_in,
    output logic [NUM_REGS-1:0]        pending
);

    reg_addr_t             w_dest_arr [NREQ];
    logic [XLEN-1:0]       w_data_arr [NREQ];
    logic [NREQ-1:0]       w_grant;
    logic                  w_granted;
    reg_addr_t             w_sel_dest;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_commit;
    logic                  w_issue_fire;

    logic                  we_q;
    reg_addr_t             dest_q;
    logic [XLEN-1:0]       data_q;
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_dest_arr[gi] = req_dest[dest_lo(gi) +: REG_ADDR_W];
            assign w_data_arr[gi] = req_data[data_lo(gi, XLEN) +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_valid),
        .grant_o (w_grant)
    );

    assign req_ready = w_grant;
    assign w_granted = |w_grant;

    // Grant is one-hot, so an OR-mux selects the winning slice.
    always_comb begin
        w_sel_dest = ZERO_REG;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dest = w_sel_dest | w_dest_arr[i];
                w_sel_data = w_sel_data | w_data_arr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            dest_q <= ZERO_REG;
            data_q <= '0;
        end else if (w_granted) begin
            we_q   <= (w_sel_dest != ZERO_REG);
            dest_q <= w_sel_dest;
            data_q <= w_sel_data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // Gating with reset keeps a held write from reaching the RF on a reset edge.
    assign w_commit        = we_q & reset;
    assign rf_write_enable = w_commit;
    assign rf_dest         = dest_q;
    assign rf_data_in      = data_q;

    assign issue_ready  = reset & ((issue_dest == ZERO_REG) | ~pending_q[issue_dest]);
    assign w_issue_fire = issue_valid & issue_ready & (issue_dest != ZERO_REG);

    always_comb begin
        pending_d = pending_q;
        if (w_commit) begin
            pending_d[dest_q] = 1'b0;
        end
        if (w_issue_fire) begin
            pending_d[issue_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending    = pending_q;
    assign hazard_one = (src_one != ZERO_REG) & pending_q[src_one];
    assign hazard_two = (src_two != ZERO_REG) & pending_q[src_two];

endmodule
`default_nettype wire
